// File: rtl/servisia_pkg.sv
// Shared types and constants for the servisia word-to-byte memory bridge.
package servisia_pkg;

  localparam int BYTE_CNT_W = 3;
  localparam int LANE_W     = 2;

  localparam logic [LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [LANE_W-1:0] LANE3 = 2'd3;

  localparam logic [3:0] SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Little-endian byte lane extraction from a 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [LANE_W-1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/servisia_byte_sched.sv
// Finds the lowest selected byte lane at or above a start position and
// reports whether it is the final selected lane of the mask.
module servisia_byte_sched
  import servisia_pkg::*;
(
  input  logic [3:0]            sel,
  input  logic [BYTE_CNT_W-1:0] start,
  output logic [LANE_W-1:0]     lane,
  output logic                  found,
  output logic                  last
);

  // Scan downward so the final hit is the lowest lane; any earlier hit means more lanes remain.
  always_comb begin
    lane  = LANE0;
    found = 1'b0;
    last  = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      if (sel[k] && (BYTE_CNT_W'(k) >= start)) begin
        last  = !found;
        found = 1'b1;
        lane  = LANE_W'(k);
      end
    end
  end

endmodule

// File: rtl/servisia_mem_ctrl.sv
// Bridges one 32-bit Wishbone classic request at a time onto the 8-bit
// servisia_mem interface as a sequence of single-byte cycles.
module servisia_mem_ctrl
  import servisia_pkg::*;
#(
  parameter int MEM_AW      = 21,
  parameter bit FLASH_WR_EN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_rdt_o,
  output logic              wb_ack_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  state_t                state, state_next;
  logic [MEM_AW-3:0]     adr_q, adr_next;
  logic [31:0]           dat_q, dat_next;
  logic [3:0]            sel_q, sel_next;
  logic [BYTE_CNT_W-1:0] cnt, cnt_next;
  logic                  last_q, last_next;
  logic                  live_q, live_next;
  logic                  ack_next, read_next, write_next;
  logic [MEM_AW-1:0]     addr_next;
  logic [7:0]            wdata_next;
  logic [31:0]           rdt_next;
  logic [3:0]            sched_sel;
  logic [BYTE_CNT_W-1:0] sched_start;
  logic [LANE_W-1:0]     sched_lane, prev_lane;
  logic                  sched_found, sched_last;
  logic                  request, write_skip;
  logic                  unused_adr;

  assign request    = wb_cyc_i & wb_stb_i;
  assign write_skip = (wb_sel_i == 4'b0000) || (!FLASH_WR_EN && !wb_adr_i[MEM_AW-1]);
  assign prev_lane  = LANE_W'(cnt - BYTE_CNT_W'(1));
  assign unused_adr = ^{wb_adr_i[31:MEM_AW], wb_adr_i[1:0]};

  servisia_byte_sched u_sched (
    .sel   (sched_sel),
    .start (sched_start),
    .lane  (sched_lane),
    .found (sched_found),
    .last  (sched_last)
  );

  // Feed the scheduler: the incoming mask when accepting, all lanes for reads, the latched mask for writes.
  always_comb begin
    sched_sel   = SEL_ALL;
    sched_start = '0;
    case (state)
      IDLE:    sched_sel = wb_sel_i;
      READ:    sched_start = cnt + BYTE_CNT_W'(1);
      WRITE: begin
        sched_sel   = sel_q;
        sched_start = cnt + BYTE_CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Next-state and next registered-output logic; strobes and ack default low every cycle.
  always_comb begin
    state_next = state;
    adr_next   = adr_q;
    dat_next   = dat_q;
    sel_next   = sel_q;
    cnt_next   = cnt;
    last_next  = last_q;
    live_next  = live_q;
    ack_next   = 1'b0;
    read_next  = 1'b0;
    write_next = 1'b0;
    addr_next  = mem_addr_o;
    wdata_next = mem_wdata_o;
    rdt_next   = wb_rdt_o;
    case (state)
      IDLE: begin
        if (request) begin
          adr_next  = wb_adr_i[MEM_AW-1:2];
          dat_next  = wb_dat_i;
          sel_next  = wb_sel_i;
          cnt_next  = '0;
          live_next = 1'b1;
          if (!wb_we_i) begin
            state_next = READ;
            read_next  = 1'b1;
            addr_next  = {wb_adr_i[MEM_AW-1:2], LANE0};
          end else if (write_skip) begin
            state_next = ACK;
            ack_next   = 1'b1;
          end else begin
            state_next = WRITE;
            write_next = 1'b1;
            addr_next  = {wb_adr_i[MEM_AW-1:2], sched_lane};
            wdata_next = lane_byte(wb_dat_i, sched_lane);
            cnt_next   = {1'b0, sched_lane};
            last_next  = sched_last;
          end
        end
      end
      READ: begin
        live_next = live_q & wb_cyc_i;
        cnt_next  = cnt + BYTE_CNT_W'(1);
        if (cnt != '0) begin
          rdt_next[{prev_lane, 3'b000} +: 8] = mem_rdata_i;
        end
        if (sched_found) begin
          read_next = 1'b1;
          addr_next = {adr_q, sched_lane};
        end
        if (cnt == BYTE_CNT_W'(4)) begin
          ack_next   = live_q & wb_cyc_i;
          state_next = ACK;
        end
      end
      WRITE: begin
        live_next = live_q & wb_cyc_i;
        if (last_q) begin
          ack_next   = live_q & wb_cyc_i;
          state_next = ACK;
        end else begin
          write_next = 1'b1;
          addr_next  = {adr_q, sched_lane};
          wdata_next = lane_byte(dat_q, sched_lane);
          cnt_next   = {1'b0, sched_lane};
          last_next  = sched_last;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latched request, sequencing counters and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      live_q      <= 1'b0;
      wb_ack_o    <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      wb_rdt_o    <= '0;
    end else begin
      adr_q       <= adr_next;
      dat_q       <= dat_next;
      sel_q       <= sel_next;
      cnt         <= cnt_next;
      last_q      <= last_next;
      live_q      <= live_next;
      wb_ack_o    <= ack_next;
      mem_read_o  <= read_next;
      mem_write_o <= write_next;
      mem_addr_o  <= addr_next;
      mem_wdata_o <= wdata_next;
      wb_rdt_o    <= rdt_next;
    end
  end

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// Directed bench for servisia_mem_ctrl with a byte memory model and an ack scoreboard.
module tb_servisia_mem_ctrl;

  localparam int MEM_AW = 21;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [31:0]       wb_adr_i, wb_dat_i, wb_rdt_o;
  logic [3:0]        wb_sel_i;
  logic              wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic              mem_read_o, mem_write_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o, mem_rdata_i;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int          ack_cycle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0]        mem_model [logic [MEM_AW-1:0]];
  logic              pre_en;
  logic [MEM_AW-1:0] pre_addr;
  logic [7:0]        pre_data;

  bit                rd_log   [64];
  bit                wr_log   [64];
  logic [MEM_AW-1:0] addr_log [64];
  logic [7:0]        wd_log   [64];
  int                ack_count, overlap_count, write_count, read_count;

  always #5 clk_i = ~clk_i;

  servisia_mem_ctrl #(.MEM_AW(MEM_AW), .FLASH_WR_EN(1'b0)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_rdt_o    (wb_rdt_o),
    .wb_ack_o    (wb_ack_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Byte memory standing in for servisia_mem: registered read data, synchronous writes.
  always @(posedge clk_i) begin
    if (pre_en) mem_model[pre_addr] = pre_data;
    if (mem_write_o) mem_model[mem_addr_o] = mem_wdata_o;
    mem_rdata_i <= mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 8'h00;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel);
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic preload(input logic [MEM_AW-1:0] addr, input logic [7:0] data);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk_i);
    pre_en   = 1'b0;
  endtask

  task automatic pushExpect(input bit is_read, input logic [31:0] rdata, input int ack_cycle);
    exp_t e;
    e.is_read   = is_read;
    e.rdata     = rdata;
    e.ack_cycle = ack_cycle;
    sb.push_back(e);
  endtask

  // Samples mid-cycle for a fixed number of cycles, scoring every ack against the scoreboard.
  task automatic traceCycles(input int ncycles, input int drop_after_acks, input int drop_at_cycle);
    exp_t e;
    ack_count     = 0;
    overlap_count = 0;
    write_count   = 0;
    read_count    = 0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk_i);
      rd_log[c]   = mem_read_o;
      wr_log[c]   = mem_write_o;
      addr_log[c] = mem_addr_o;
      wd_log[c]   = mem_wdata_o;
      if (mem_read_o && mem_write_o) overlap_count++;
      if (mem_write_o) write_count++;
      if (mem_read_o) read_count++;
      if (wb_ack_o) begin
        ack_count++;
        checkOutput("ack_has_pending_request", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("ack_cycle", 64'(c), 64'(e.ack_cycle));
          if (e.is_read) checkOutput("read_data", 64'(wb_rdt_o), 64'(e.rdata));
        end
        if (ack_count == drop_after_acks) begin
          wb_cyc_i = 1'b0;
          wb_stb_i = 1'b0;
        end
      end
      if (c == drop_at_cycle) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
    checkOutput("strobe_overlap", 64'(overlap_count), 64'd0);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_ni   = 1'b0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_outputs",
                {wb_ack_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, wb_rdt_o}, 64'd0);

    preload(21'h100004, 8'h11);
    preload(21'h100005, 8'h22);
    preload(21'h100006, 8'h33);
    preload(21'h100007, 8'h44);
    preload(21'h100010, 8'hA0);
    preload(21'h100011, 8'hA1);
    preload(21'h100012, 8'hA2);
    preload(21'h100013, 8'hA3);
    preload(21'h000040, 8'h99);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("[TB] read word at 0x100004");
    pushExpect(1'b1, 32'h44332211, 5);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
    traceCycles(7, 1, -1);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("read_strobe_c%0d", c), 64'(rd_log[c]), 64'd1);
      checkOutput($sformatf("read_addr_c%0d", c), 64'(addr_log[c]), 64'(21'h100004 + c));
    end
    checkOutput("read_count", 64'(read_count), 64'd4);
    checkOutput("read_ack_count", 64'(ack_count), 64'd1);
    checkOutput("read_no_writes", 64'(write_count), 64'd0);

    $display("[TB] write 0xDEADBEEF sel 0101 at 0x100010");
    pushExpect(1'b0, 32'h0, 2);
    applyStimulus(1'b1, 32'h0010_0010, 32'hDEAD_BEEF, 4'b0101);
    traceCycles(4, 1, -1);
    checkOutput("wr_count", 64'(write_count), 64'd2);
    checkOutput("wr0_strobe", 64'(wr_log[0]), 64'd1);
    checkOutput("wr0_addr", 64'(addr_log[0]), 64'(21'h100010));
    checkOutput("wr0_data", 64'(wd_log[0]), 64'(8'hEF));
    checkOutput("wr1_strobe", 64'(wr_log[1]), 64'd1);
    checkOutput("wr1_addr", 64'(addr_log[1]), 64'(21'h100012));
    checkOutput("wr1_data", 64'(wd_log[1]), 64'(8'hAD));
    checkOutput("wr_no_reads", 64'(read_count), 64'd0);

    pushExpect(1'b1, 32'hA3AD_A1EF, 5);
    applyStimulus(1'b0, 32'h0010_0010, 32'h0, 4'hF);
    traceCycles(7, 1, -1);
    checkOutput("readback_ack_count", 64'(ack_count), 64'd1);

    $display("[TB] skipped writes");
    pushExpect(1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h0010_0020, 32'hCAFE_F00D, 4'b0000);
    traceCycles(2, 1, -1);
    checkOutput("sel0_writes", 64'(write_count), 64'd0);
    checkOutput("sel0_ack_count", 64'(ack_count), 64'd1);

    pushExpect(1'b0, 32'h0, 0);
    applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b1111);
    traceCycles(2, 1, -1);
    checkOutput("flash_writes", 64'(write_count), 64'd0);
    checkOutput("flash_ack_count", 64'(ack_count), 64'd1);
    checkOutput("flash_byte_kept", 64'(mem_model[21'h000040]), 64'(8'h99));

    $display("[TB] back-to-back reads with stb held");
    pushExpect(1'b1, 32'h44332211, 5);
    pushExpect(1'b1, 32'h44332211, 12);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
    traceCycles(14, 2, -1);
    checkOutput("b2b_ack_count", 64'(ack_count), 64'd2);
    checkOutput("b2b_idle_c6", 64'(rd_log[6]), 64'd0);
    checkOutput("b2b_accept_c7", 64'(rd_log[7]), 64'd1);
    checkOutput("b2b_addr_c7", 64'(addr_log[7]), 64'(21'h100004));
    checkOutput("b2b_read_count", 64'(read_count), 64'd8);

    $display("[TB] cyc dropped during a write");
    applyStimulus(1'b1, 32'h0010_0030, 32'h0102_0304, 4'b1111);
    traceCycles(7, 1, 1);
    checkOutput("abort_ack_count", 64'(ack_count), 64'd0);
    checkOutput("abort_write_count", 64'(write_count), 64'd4);
    pushExpect(1'b1, 32'h0102_0304, 5);
    applyStimulus(1'b0, 32'h0010_0030, 32'h0, 4'hF);
    traceCycles(7, 1, -1);

    $display("[TB] asynchronous reset during read cycle 2");
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
    repeat (3) @(posedge clk_i);
    #2;
    checkOutput("pre_reset_read_strobe", 64'(mem_read_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {wb_ack_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, wb_rdt_o}, 64'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    traceCycles(5, 1, -1);
    checkOutput("reset_no_ack", 64'(ack_count), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    pushExpect(1'b1, 32'h44332211, 5);
    applyStimulus(1'b0, 32'h0010_0004, 32'h0, 4'hF);
    traceCycles(7, 1, -1);
    checkOutput("post_reset_ack_count", 64'(ack_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
